// File: rtl/axi_decerr_slave_if.sv
// AXI4 bundle between the interconnect's unmapped-address port and the default slave.
// No logic and no latency; it only groups the AW/W/B/AR/R channel signals.
// Backpressure is carried by the channel valid/ready pairs.
interface axi_decerr_slave_if #(
   parameter int ID_W   = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
);
   logic [ID_W-1:0]     awid_i;
   logic [ADDR_W-1:0]   awaddr_i;
   logic [LEN_W-1:0]    awlen_i;
   logic [2:0]          awsize_i;
   logic [1:0]          awburst_i;
   logic                awvalid_i;
   logic                awready_o;

   logic [DATA_W-1:0]   wdata_i;
   logic [DATA_W/8-1:0] wstrb_i;
   logic                wlast_i;
   logic                wvalid_i;
   logic                wready_o;

   logic [ID_W-1:0]     bid_o;
   logic [1:0]          bresp_o;
   logic                bvalid_o;
   logic                bready_i;

   logic [ID_W-1:0]     arid_i;
   logic [ADDR_W-1:0]   araddr_i;
   logic [LEN_W-1:0]    arlen_i;
   logic [2:0]          arsize_i;
   logic [1:0]          arburst_i;
   logic                arvalid_i;
   logic                arready_o;

   logic [ID_W-1:0]     rid_o;
   logic [DATA_W-1:0]   rdata_o;
   logic [1:0]          rresp_o;
   logic                rlast_o;
   logic                rvalid_o;
   logic                rready_i;

   modport slave (
      input  awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
      output awready_o,
      input  wdata_i, wstrb_i, wlast_i, wvalid_i,
      output wready_o,
      output bid_o, bresp_o, bvalid_o,
      input  bready_i,
      input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i,
      output arready_o,
      output rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
      input  rready_i
   );

   modport master (
      output awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
      input  awready_o,
      output wdata_i, wstrb_i, wlast_i, wvalid_i,
      input  wready_o,
      input  bid_o, bresp_o, bvalid_o,
      output bready_i,
      output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i,
      input  arready_o,
      input  rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
      output rready_i
   );
endinterface

// File: rtl/axi_decerr_slave.sv
// AXI4 default slave: completes any burst with ERR_RESP; optional error log under `DECERR_LOG_EN.
// Latency: write B one cycle after WLAST; first R beat one cycle after the AR handshake.
// Backpressure: one outstanding burst per direction; B and R payload held while ready is low.
module axi_decerr_slave #(
   parameter int               ID_W       = 8,
   parameter int               ADDR_W     = 32,
   parameter int               DATA_W     = 32,
   parameter int               LEN_W      = 4,
   parameter logic [1:0]       ERR_RESP   = 2'b11,
   parameter logic [DATA_W-1:0] RDATA_FILL = {DATA_W{1'b0}}
) (
   input  logic               clk,
   input  logic               rst,
   axi_decerr_slave_if.slave  bus
`ifdef DECERR_LOG_EN
   ,
   output logic [15:0]        err_cnt_o,
   output logic [ADDR_W-1:0]  err_addr_o
`endif
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   w_state_t         w_state_q, w_state_d;
   r_state_t         r_state_q, r_state_d;

   logic [ID_W-1:0]  w_id_q;
   logic [LEN_W-1:0] w_len_q;
   logic [LEN_W-1:0] w_cnt_q;
   logic [ID_W-1:0]  r_id_q;
   logic [LEN_W-1:0] r_len_q;
   logic [LEN_W-1:0] r_cnt_q;

   logic aw_rdy, w_rdy, b_vld;
   logic ar_rdy, r_vld;
   logic aw_hs, w_hs, ar_hs, r_hs;
   logic r_last;

   // Address-channel ready is forced low while reset is asserted, even though the FSMs sit in IDLE.
   assign bus.awready_o = aw_rdy & rst;
   assign bus.arready_o = ar_rdy & rst;
   assign bus.wready_o  = w_rdy;
   assign bus.bvalid_o  = b_vld;
   assign bus.bid_o     = w_id_q;
   assign bus.bresp_o   = ERR_RESP;
   assign bus.rvalid_o  = r_vld;
   assign bus.rid_o     = r_id_q;
   assign bus.rdata_o   = RDATA_FILL;
   assign bus.rresp_o   = ERR_RESP;
   assign bus.rlast_o   = r_last;

   assign aw_hs  = bus.awvalid_i & bus.awready_o;
   assign w_hs   = bus.wvalid_i  & w_rdy;
   assign ar_hs  = bus.arvalid_i & bus.arready_o;
   assign r_hs   = r_vld & bus.rready_i;
   assign r_last = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);

   // Payload, size and burst type never affect the error response; the captured write length
   // and beat count are kept for observability only.
   logic unused_ok;
   assign unused_ok = ^{bus.awaddr_i, bus.awsize_i, bus.awburst_i, bus.wdata_i, bus.wstrb_i,
                        bus.araddr_i, bus.arsize_i, bus.arburst_i, w_len_q, w_cnt_q};

   // Write and read FSM state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
      end
   end

   // Write FSM: accept AW, sink W beats until WLAST, then hold B until accepted.
   always_comb begin
      w_state_d = w_state_q;
      aw_rdy    = 1'b0;
      w_rdy     = 1'b0;
      b_vld     = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            aw_rdy = 1'b1;
            if (bus.awvalid_i) w_state_d = W_DATA;
         end
         W_DATA: begin
            w_rdy = 1'b1;
            if (bus.wvalid_i && bus.wlast_i) w_state_d = W_RESP;
         end
         W_RESP: begin
            b_vld = 1'b1;
            if (bus.bready_i) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read FSM: accept AR, then stream len+1 error beats.
   always_comb begin
      r_state_d = r_state_q;
      ar_rdy    = 1'b0;
      r_vld     = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            ar_rdy = 1'b1;
            if (bus.arvalid_i) r_state_d = R_DATA;
         end
         R_DATA: begin
            r_vld = 1'b1;
            if (bus.rready_i && r_last) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write-side capture: ID and length on AW, beat counter on each W handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_id_q  <= '0;
         w_len_q <= '0;
         w_cnt_q <= '0;
      end else if (aw_hs) begin
         w_id_q  <= bus.awid_i;
         w_len_q <= bus.awlen_i;
         w_cnt_q <= '0;
      end else if (w_hs) begin
         w_cnt_q <= w_cnt_q + LEN_W'(1);
      end
   end

   // Read-side capture: ID and length on AR; counter steps per beat and clears after the last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_id_q  <= '0;
         r_len_q <= '0;
         r_cnt_q <= '0;
      end else if (ar_hs) begin
         r_id_q  <= bus.arid_i;
         r_len_q <= bus.arlen_i;
         r_cnt_q <= '0;
      end else if (r_hs) begin
         r_cnt_q <= r_last ? '0 : r_cnt_q + LEN_W'(1);
      end
   end

`ifdef DECERR_LOG_EN
   logic [16:0] err_sum;
   assign err_sum = {1'b0, err_cnt_o} + 17'(aw_hs) + 17'(ar_hs);

   // Error log: saturating request count and last errored address (AR wins a same-cycle tie).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt_o  <= '0;
         err_addr_o <= '0;
      end else begin
         err_cnt_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
         if (ar_hs)      err_addr_o <= bus.araddr_i;
         else if (aw_hs) err_addr_o <= bus.awaddr_i;
      end
   end
`endif

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed self-checking bench for axi_decerr_slave.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Log checks are included when DECERR_LOG_EN is defined.
module tb_axi_decerr_slave;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

`ifdef DECERR_LOG_EN
   logic [15:0] err_cnt;
   logic [31:0] err_addr;
`endif

   axi_decerr_slave_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

   axi_decerr_slave dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef DECERR_LOG_EN
      ,
      .err_cnt_o  (err_cnt),
      .err_addr_o (err_addr)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef DECERR_LOG_EN
   task automatic do_write(input logic [31:0] addr);
      bus.awaddr_i = addr; bus.awlen_i = 4'd0; bus.awvalid_i = 1'b1;
      tick();
      bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b1; bus.wlast_i = 1'b1;
      tick();
      bus.wvalid_i = 1'b0; bus.wlast_i = 1'b0; bus.bready_i = 1'b1;
      tick();
      bus.bready_i = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr);
      bus.araddr_i = addr; bus.arlen_i = 4'd0; bus.arvalid_i = 1'b1;
      tick();
      bus.arvalid_i = 1'b0; bus.rready_i = 1'b1;
      tick();
      bus.rready_i = 1'b0;
   endtask
`endif

   initial begin
      int beats, rbeats, wbeats, b_cyc, rlast_cyc;
      logic stalled;
      logic [40:0] saved;

      bus.awid_i = '0; bus.awaddr_i = '0; bus.awlen_i = '0; bus.awsize_i = 3'd2;
      bus.awburst_i = 2'b01; bus.awvalid_i = 1'b0;
      bus.wdata_i = 32'hDEAD_BEEF; bus.wstrb_i = 4'hF; bus.wlast_i = 1'b0; bus.wvalid_i = 1'b0;
      bus.bready_i = 1'b0;
      bus.arid_i = '0; bus.araddr_i = '0; bus.arlen_i = '0; bus.arsize_i = 3'd2;
      bus.arburst_i = 2'b01; bus.arvalid_i = 1'b0;
      bus.rready_i = 1'b0;

      // ---- reset state (valids asserted to show ready is gated by reset) ----
      bus.awvalid_i = 1'b1; bus.arvalid_i = 1'b1;
      #12;
      check("rst_awready", bus.awready_o, 0);
      check("rst_arready", bus.arready_o, 0);
      check("rst_wready",  bus.wready_o,  0);
      check("rst_bvalid",  bus.bvalid_o,  0);
      check("rst_rvalid",  bus.rvalid_o,  0);
      check("rst_rlast",   bus.rlast_o,   0);
      check("rst_bid",     bus.bid_o,     0);
      check("rst_rid",     bus.rid_o,     0);
      check("rst_bresp",   bus.bresp_o,   2'b11);
      check("rst_rresp",   bus.rresp_o,   2'b11);
      check("rst_rdata",   bus.rdata_o,   0);
`ifdef DECERR_LOG_EN
      check("rst_err_cnt", err_cnt, 0);
`endif
      bus.awvalid_i = 1'b0; bus.arvalid_i = 1'b0;
      @(negedge clk); rst = 1'b1;
      tick();

      // ---- single-beat write, minimum latency ----
      check("w0_awready", bus.awready_o, 1);
      check("w0_wready_idle", bus.wready_o, 0);
      bus.awid_i = 8'h12; bus.awlen_i = 4'd0; bus.awaddr_i = 32'hF000_0000; bus.awvalid_i = 1'b1;
      tick();                                    // cycle N: AW accepted
      bus.awvalid_i = 1'b0;
      check("w0_awready_busy", bus.awready_o, 0);
      check("w0_wready", bus.wready_o, 1);
      check("w0_bvalid_early", bus.bvalid_o, 0);
      bus.wvalid_i = 1'b1; bus.wlast_i = 1'b1;
      tick();                                    // cycle N+1: W accepted
      bus.wvalid_i = 1'b0; bus.wlast_i = 1'b0;
      check("w0_bvalid", bus.bvalid_o, 1);       // cycle N+2
      check("w0_bid", bus.bid_o, 8'h12);
      check("w0_bresp", bus.bresp_o, 2'b11);
      check("w0_wready_resp", bus.wready_o, 0);
      bus.bready_i = 1'b1;
      tick();
      bus.bready_i = 1'b0;
      check("w0_bvalid_done", bus.bvalid_o, 0);
      check("w0_awready_back", bus.awready_o, 1);

      // ---- len=3 write with wvalid gaps and stalled B ----
      bus.awid_i = 8'h33; bus.awlen_i = 4'd3; bus.awvalid_i = 1'b1;
      tick();
      bus.awvalid_i = 1'b0;
      beats = 0;
      for (int c = 0; c < 20 && !bus.bvalid_o; c++) begin
         bus.wvalid_i = (c % 2 == 0);
         bus.wlast_i  = (beats == 3);
         if (bus.wvalid_i && bus.wready_o) beats++;
         tick();
      end
      bus.wvalid_i = 1'b0; bus.wlast_i = 1'b0;
      check("w3_beats", beats, 4);
      for (int c = 0; c < 3; c++) begin
         check("w3_bvalid_hold", bus.bvalid_o, 1);
         check("w3_bid", bus.bid_o, 8'h33);
         check("w3_awready_busy", bus.awready_o, 0);
         tick();
      end
      bus.bready_i = 1'b1;
      check("w3_bvalid_at_ready", bus.bvalid_o, 1);
      tick();
      bus.bready_i = 1'b0;
      check("w3_bvalid_done", bus.bvalid_o, 0);
      check("w3_awready_back", bus.awready_o, 1);

      // ---- len=7 read with rready toggling ----
      bus.arid_i = 8'h05; bus.arlen_i = 4'd7; bus.araddr_i = 32'hE000_0000; bus.arvalid_i = 1'b1;
      check("r7_arready", bus.arready_o, 1);
      tick();
      bus.arvalid_i = 1'b0;
      check("r7_arready_busy", bus.arready_o, 0);
      beats = 0; stalled = 1'b0; saved = '0;
      for (int c = 0; c < 40 && beats < 8; c++) begin
         bus.rready_i = (c % 2 == 1);
         check("r7_rvalid", bus.rvalid_o, 1);
         if (stalled) check("r7_stable", {bus.rid_o, bus.rlast_o, bus.rdata_o}, saved);
         if (bus.rready_i) begin
            beats++;
            check("r7_rid", bus.rid_o, 8'h05);
            check("r7_rdata", bus.rdata_o, 0);
            check("r7_rresp", bus.rresp_o, 2'b11);
            check("r7_rlast", bus.rlast_o, beats == 8);
            stalled = 1'b0;
         end else begin
            saved = {bus.rid_o, bus.rlast_o, bus.rdata_o};
            stalled = 1'b1;
         end
         tick();
      end
      bus.rready_i = 1'b0;
      check("r7_beats", beats, 8);
      check("r7_rvalid_done", bus.rvalid_o, 0);
      check("r7_arready_back", bus.arready_o, 1);

      // ---- simultaneous AR len=15 and AW len=1 ----
      bus.awid_i = 8'h44; bus.awlen_i = 4'd1; bus.awaddr_i = 32'h9000_0000; bus.awvalid_i = 1'b1;
      bus.arid_i = 8'h66; bus.arlen_i = 4'd15; bus.araddr_i = 32'h8000_0000; bus.arvalid_i = 1'b1;
      check("cc_awready", bus.awready_o, 1);
      check("cc_arready", bus.arready_o, 1);
      tick();
      bus.awvalid_i = 1'b0; bus.arvalid_i = 1'b0;
      bus.rready_i = 1'b1; bus.bready_i = 1'b1;
      rbeats = 0; wbeats = 0; b_cyc = -1; rlast_cyc = -1;
      for (int c = 0; c < 40 && (rbeats < 16 || b_cyc < 0); c++) begin
         bus.wvalid_i = (wbeats < 2);
         bus.wlast_i  = (wbeats == 1);
         if (c < 16) check("cc_rvalid", bus.rvalid_o, 1);
         if (bus.rvalid_o) begin
            rbeats++;
            check("cc_rid", bus.rid_o, 8'h66);
            check("cc_rlast", bus.rlast_o, rbeats == 16);
            if (bus.rlast_o) rlast_cyc = c;
         end
         if (bus.wvalid_i && bus.wready_o) wbeats++;
         if (bus.bvalid_o) begin
            b_cyc = c;
            check("cc_bid", bus.bid_o, 8'h44);
         end
         tick();
      end
      bus.wvalid_i = 1'b0; bus.wlast_i = 1'b0; bus.rready_i = 1'b0; bus.bready_i = 1'b0;
      check("cc_rbeats", rbeats, 16);
      check("cc_rlast_cyc", rlast_cyc, 15);
      check("cc_wbeats", wbeats, 2);
      check("cc_b_cyc", b_cyc, 2);
      check("cc_rvalid_done", bus.rvalid_o, 0);
`ifdef DECERR_LOG_EN
      check("cc_err_cnt", err_cnt, 5);
      check("cc_err_addr", err_addr, 32'h8000_0000);
`endif

      // ---- reset mid-burst during beat 3 of len=7 read ----
      bus.arid_i = 8'h09; bus.arlen_i = 4'd7; bus.arvalid_i = 1'b1;
      tick();
      bus.arvalid_i = 1'b0; bus.rready_i = 1'b1;
      tick();
      tick();                                    // two beats taken, beat 3 on the bus
      check("rr_rvalid_b3", bus.rvalid_o, 1);
      check("rr_rlast_b3", bus.rlast_o, 0);
      #2 rst = 1'b0;
      #1;
      check("rr_rvalid_rst", bus.rvalid_o, 0);
      check("rr_rlast_rst", bus.rlast_o, 0);
      check("rr_rid_rst", bus.rid_o, 0);
      check("rr_arready_rst", bus.arready_o, 0);
      @(negedge clk); rst = 1'b1;
      tick();
      check("rr_arready_after", bus.arready_o, 1);
      for (int c = 0; c < 3; c++) begin
         check("rr_no_residual", bus.rvalid_o, 0);
         tick();
      end
      bus.rready_i = 1'b0;

`ifdef DECERR_LOG_EN
      // ---- error log: 3 writes then 2 reads ----
      check("log_cnt_cleared", err_cnt, 0);
      do_write(32'h1000_0000);
      do_write(32'h1000_0004);
      do_write(32'h1000_0008);
      do_read(32'h4000_0000);
      do_read(32'h4000_0010);
      check("log_err_cnt", err_cnt, 5);
      check("log_err_addr", err_addr, 32'h4000_0010);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
